pipe_if_id_buf: RTL and testbench

//  Two-entry skid buffer and pipeline register between the IF stage and the ID stage.
//  - Captures {pc, instr} from IF under a valid/allowin handshake.
//  - Presents the oldest entry to ID, and drives IF's id_allowin from a registered "not full".
//  - Holds fetched instructions while ID stalls. Drops everything on flush_if_id.
//  - Counts ID stall cycles for performance debug.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_if_id_buf.sv | 112 +++++++++++
 tb/tb_pipe_if_id_buf.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: buffer occupancy encoding and the default-width entry payload.
package pipe_pkg;

  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_STALL_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } buf_state_t;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_if_id_buf.sv
// Two-entry skid buffer between IF and ID: FIFO-ordered head/tail storage,
// registered allowin/valid, flush to empty, and a saturating ID stall counter.
module pipe_if_id_buf
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     STALL_W  = DEF_STALL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_in,
  input  logic [PC_W-1:0]    if_pc_in,
  input  logic [INSTR_W-1:0] if_instr_in,
  input  logic               flush_if_id,
  input  logic               id_allowin_in,
  output logic               if_id_allowin,
  output logic               id_valid_out,
  output logic [PC_W-1:0]    id_pc_out,
  output logic [INSTR_W-1:0] id_instr_out,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  buf_state_t state_q, state_nxt;
  entry_t     head_q, head_nxt;
  entry_t     tail_q, tail_nxt;
  entry_t     in_entry;
  logic       allowin_q;
  logic       valid_q;
  logic       push;
  logic       pop;
  logic       stall_inc;

  assign in_entry.pc    = if_pc_in;
  assign in_entry.instr = if_instr_in;

  // Handshakes use only registered status, so no id_allowin_in -> if_id_allowin path.
  assign push      = if_valid_in & allowin_q & ~flush_if_id;
  assign pop       = valid_q & id_allowin_in & ~flush_if_id;
  assign stall_inc = valid_q & ~id_allowin_in & ~flush_if_id;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= EMPTY;
      head_q    <= '{pc: RESET_PC, instr: '0};
      tail_q    <= '{pc: RESET_PC, instr: '0};
      allowin_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      head_q    <= head_nxt;
      tail_q    <= tail_nxt;
      allowin_q <= (state_nxt != FULL);
      valid_q   <= (state_nxt != EMPTY);
    end
  end

  // Flush only clears occupancy; stored data is left as-is.
  always_comb begin
    state_nxt = state_q;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    if (flush_if_id) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_nxt  = in_entry;
            state_nxt = HALF;
          end
        end
        HALF: begin
          if (push && pop) begin
            head_nxt = in_entry;
          end else if (push) begin
            tail_nxt  = in_entry;
            state_nxt = FULL;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_nxt  = tail_q;
            state_nxt = HALF;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  assign if_id_allowin = allowin_q;
  assign id_valid_out  = valid_q;
  assign id_pc_out     = head_q.pc;
  assign id_instr_out  = head_q.instr;

endmodule

// File: tb/tb_pipe_if_id_buf.sv
// Directed bench for pipe_if_id_buf: reset, streaming, stall fill/drain, flush, push+pop, saturation.
module tb_pipe_if_id_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_in;
  logic [31:0] if_pc_in;
  logic [31:0] if_instr_in;
  logic        flush_if_id;
  logic        id_allowin_in;
  logic        if_id_allowin;
  logic        id_valid_out;
  logic [31:0] id_pc_out;
  logic [31:0] id_instr_out;
  logic [15:0] stall_cnt;

  logic        s_allowin;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic [1:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_if_id_buf dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid_in   (if_valid_in),
    .if_pc_in      (if_pc_in),
    .if_instr_in   (if_instr_in),
    .flush_if_id   (flush_if_id),
    .id_allowin_in (id_allowin_in),
    .if_id_allowin (if_id_allowin),
    .id_valid_out  (id_valid_out),
    .id_pc_out     (id_pc_out),
    .id_instr_out  (id_instr_out),
    .stall_cnt     (stall_cnt)
  );

  // Narrow-counter instance shares all inputs; used for the saturation check.
  pipe_if_id_buf #(.STALL_W(2)) dut_s (
    .clk           (clk),
    .rst           (rst),
    .if_valid_in   (if_valid_in),
    .if_pc_in      (if_pc_in),
    .if_instr_in   (if_instr_in),
    .flush_if_id   (flush_if_id),
    .id_allowin_in (id_allowin_in),
    .if_id_allowin (s_allowin),
    .id_valid_out  (s_valid),
    .id_pc_out     (s_pc),
    .id_instr_out  (s_instr),
    .stall_cnt     (s_stall_cnt)
  );

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    if_valid_in = v;
    if_pc_in    = pc;
    if_instr_in = ins(pc);
  endtask

  task automatic expect_head(input string name, input logic v, input logic [31:0] pc, input logic allow);
    checks++;
    if (id_valid_out !== v) begin
      errors++;
      $display("FAIL %s valid: got %b want %b", name, id_valid_out, v);
    end
    checks++;
    if (if_id_allowin !== allow) begin
      errors++;
      $display("FAIL %s allowin: got %b want %b", name, if_id_allowin, allow);
    end
    if (v) begin
      checks++;
      if (id_pc_out !== pc || id_instr_out !== ins(pc)) begin
        errors++;
        $display("FAIL %s head: got pc %h instr %h want pc %h instr %h",
                 name, id_pc_out, id_instr_out, pc, ins(pc));
      end
    end
  endtask

  task automatic expect_stall(input string name, input logic [15:0] want);
    checks++;
    if (stall_cnt !== want) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush_if_id = 1'b0;
    id_allowin_in = 1'b0;
    offer(1'b1, 32'h0000_0bad);
    step();
    step();
    checks++;
    if (id_valid_out !== 1'b0 || if_id_allowin !== 1'b1 || id_pc_out !== 32'h0 ||
        id_instr_out !== 32'h0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset: got v=%b a=%b pc=%h instr=%h sc=%0d want 0 1 0 0 0",
               id_valid_out, if_id_allowin, id_pc_out, id_instr_out, stall_cnt);
    end
    rst = 1'b1;
    offer(1'b0, 32'h0);
    step();
    expect_head("reset_idle", 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    id_allowin_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, pcs[i]);
      step();
      expect_head("stream", 1'b1, pcs[i], 1'b1);
    end
    offer(1'b0, 32'h0);
    step();
    expect_head("stream_drain", 1'b0, 32'h0, 1'b1);
    expect_stall("stream", 16'd0);
  endtask

  task automatic test_stall_fill();
    id_allowin_in = 1'b0;
    offer(1'b1, 32'h10);
    step();
    expect_head("fill_half", 1'b1, 32'h10, 1'b1);
    offer(1'b1, 32'h14);
    step();
    expect_head("fill_full", 1'b1, 32'h10, 1'b0);
    // IF keeps offering while full; the offer must be ignored.
    offer(1'b1, 32'h99);
    for (int i = 0; i < 3; i++) step();
    expect_head("fill_hold", 1'b1, 32'h10, 1'b0);
    expect_stall("fill_hold", 16'd4);
    offer(1'b0, 32'h0);
    id_allowin_in = 1'b1;
    #1;
    expect_head("drain_first", 1'b1, 32'h10, 1'b0);
    step();
    expect_head("drain_second", 1'b1, 32'h14, 1'b1);
    step();
    expect_head("drain_empty", 1'b0, 32'h0, 1'b1);
    expect_stall("drain", 16'd4);
  endtask

  task automatic test_flush();
    id_allowin_in = 1'b0;
    offer(1'b1, 32'h40);
    step();
    offer(1'b1, 32'h44);
    step();
    expect_head("flush_pre", 1'b1, 32'h40, 1'b0);
    offer(1'b1, 32'h18);
    flush_if_id = 1'b1;
    step();
    flush_if_id = 1'b0;
    expect_head("flush_post", 1'b0, 32'h0, 1'b1);
    expect_stall("flush_not_counted", 16'd5);
    offer(1'b0, 32'h0);
    id_allowin_in = 1'b1;
    step();
    expect_head("flush_no_0x18", 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    id_allowin_in = 1'b1;
    offer(1'b1, 32'h20);
    step();
    expect_head("b2b_head", 1'b1, 32'h20, 1'b1);
    offer(1'b1, 32'h24);
    step();
    expect_head("b2b_swap", 1'b1, 32'h24, 1'b1);
    offer(1'b0, 32'h0);
    step();
    expect_head("b2b_empty", 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_full_and_saturate();
    // Counter is at 5; fill and hold one cycle to reach 7 while full.
    id_allowin_in = 1'b0;
    offer(1'b1, 32'h50);
    step();
    offer(1'b1, 32'h54);
    step();
    offer(1'b0, 32'h0);
    step();
    expect_head("rf_full", 1'b1, 32'h50, 1'b0);
    expect_stall("rf_pre", 16'd7);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (id_valid_out !== 1'b0 || if_id_allowin !== 1'b1 || stall_cnt !== 16'd0 ||
        id_pc_out !== 32'h0 || id_instr_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_full: got v=%b a=%b sc=%0d pc=%h instr=%h want 0 1 0 0 0",
               id_valid_out, if_id_allowin, stall_cnt, id_pc_out, id_instr_out);
    end
    offer(1'b1, 32'h60);
    step();
    offer(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    expect_stall("sat_wide", 16'd5);
    checks++;
    if (s_stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_narrow stall_cnt: got %0d want 3", s_stall_cnt);
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h60) begin
      errors++;
      $display("FAIL sat_narrow head: got v=%b pc=%h want 1 00000060", s_valid, s_pc);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_back_to_back();
    test_reset_full_and_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
